pipe_arbiter: RTL and testbench

- Round-robin arbiter that shares one fixed-latency pipelined DSP unit (multiplier, filter MAC) among N requesters.
- Issues at most one operation per cycle and drives the unit's input mux select and valid strobe.
- Carries the requester index down a LATENCY-deep tag pipeline, so each result-ready strobe returns to the requester that issued it.
- Sits between DSP channel engines and the shared arithmetic unit.

---
 rtl/pipe_arbiter_if.sv | 25 ++
 rtl/pipe_arbiter.sv | 95 +++++++++
 tb/tb_pipe_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipe_arbiter_if.sv
// Handshake bundle between channel engines and the shared-unit arbiter.
// The lock vector exists only when PIPE_ARB_LOCK_EN is defined.
interface pipe_arbiter_if #(
   parameter int N    = 4,
   parameter int SELW = 2
);
   logic            en;
   logic [N-1:0]    req;
`ifdef PIPE_ARB_LOCK_EN
   logic [N-1:0]    lock;
`endif
   logic [N-1:0]    grant;
   logic            in_valid;
   logic [SELW-1:0] sel;
   logic [N-1:0]    done;
   logic            busy;

`ifdef PIPE_ARB_LOCK_EN
   modport master (output en, req, lock, input grant, in_valid, sel, done, busy);
   modport slave  (input en, req, lock, output grant, in_valid, sel, done, busy);
`else
   modport master (output en, req, input grant, in_valid, sel, done, busy);
   modport slave  (input en, req, output grant, in_valid, sel, done, busy);
`endif
endinterface

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter for a shared fixed-latency DSP unit, with a tag pipeline
// routing each result strobe back to its issuer. Optional burst lock: PIPE_ARB_LOCK_EN.
module pipe_arbiter #(
   parameter int N       = 4,
   parameter int LATENCY = 3,
   parameter int SELW    = 2
) (
   input  logic          ck,
   input  logic          rst,
   pipe_arbiter_if.slave bus
);

   localparam logic [N-1:0]    ONE  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [SELW-1:0] LAST = SELW'(N - 1);

   logic [N-1:0]       r_grant;
   logic               r_in_valid;
   logic [SELW-1:0]    r_sel;
   logic [SELW-1:0]    r_ptr;
   logic [LATENCY-1:0] r_tag_vld;
   logic [SELW-1:0]    r_tag_sel [LATENCY];

   logic [N-1:0]       w_elig;
   logic               w_found;
   logic               w_hold;
   logic [SELW-1:0]    w_win;
   logic [SELW-1:0]    w_ptr_nxt;

   always_comb begin
      int idx;
      w_hold  = 1'b0;
`ifdef PIPE_ARB_LOCK_EN
      w_hold  = r_in_valid && bus.lock[r_sel] && bus.req[r_sel];
`endif
      w_elig  = bus.req & ~r_grant;
      w_found = 1'b0;
      w_win   = r_ptr;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(r_ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!w_found && w_elig[idx]) begin
            w_found = 1'b1;
            w_win   = SELW'(idx);
         end
      end
      // A locked grantee bypasses both the mask and the pointer.
      if (w_hold) begin
         w_found = 1'b1;
         w_win   = r_sel;
      end
      w_ptr_nxt = (w_win == LAST) ? '0 : w_win + 1'b1;
   end

   // Issue stage: grant / in_valid / sel registered from this cycle's decision
   always_ff @(posedge ck) begin
      if (rst) begin
         r_grant    <= '0;
         r_in_valid <= 1'b0;
         r_sel      <= '0;
         r_ptr      <= '0;
      end else begin
         r_grant    <= '0;
         r_in_valid <= 1'b0;
         if (bus.en && w_found) begin
            r_grant    <= ONE << w_win;
            r_in_valid <= 1'b1;
            r_sel      <= w_win;
            if (!w_hold) r_ptr <= w_ptr_nxt;
         end
      end
   end

   // Tag stages: valid bits are control, select indices are plain data
   always_ff @(posedge ck) begin
      if (rst) begin
         r_tag_vld <= '0;
      end else begin
         r_tag_vld[0] <= r_in_valid;
         for (int i = 1; i < LATENCY; i++) r_tag_vld[i] <= r_tag_vld[i-1];
      end
   end

   always_ff @(posedge ck) begin
      r_tag_sel[0] <= r_sel;
      for (int i = 1; i < LATENCY; i++) r_tag_sel[i] <= r_tag_sel[i-1];
   end

   assign bus.grant    = r_grant;
   assign bus.in_valid = r_in_valid;
   assign bus.sel      = r_sel;
   assign bus.done     = r_tag_vld[LATENCY-1] ? (ONE << r_tag_sel[LATENCY-1]) : '0;
   assign bus.busy     = r_in_valid | (|r_tag_vld);

endmodule

// File: tb/tb_pipe_arbiter.sv
// Directed bench for pipe_arbiter (N=4, LATENCY=3): vector table plus
// hand sequences for mid-operation reset and the optional burst lock.
module tb_pipe_arbiter;

   logic ck = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 ck = ~ck;

   pipe_arbiter_if #(.N(4), .SELW(2)) bus ();

   pipe_arbiter #(.N(4), .LATENCY(3), .SELW(2)) dut (
      .ck  (ck),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic       rst;
      logic       en;
      logic [3:0] req;
      logic [3:0] grant;
      logic       iv;
      logic [1:0] sel;
      logic [3:0] done;
      logic       busy;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic iv,
                          input logic [1:0] s, input logic [3:0] d, input logic b);
      chk({tag, ".grant"},    8'(bus.grant),    8'(g));
      chk({tag, ".in_valid"}, 8'(bus.in_valid), 8'(iv));
      chk({tag, ".sel"},      8'(bus.sel),      8'(s));
      chk({tag, ".done"},     8'(bus.done),     8'(d));
      chk({tag, ".busy"},     8'(bus.busy),     8'(b));
   endtask

   initial begin
      // single request, latency and drain
      tbl.push_back('{0, 1, 4'b0001, 4'b0001, 1, 2'd0, 4'b0000, 1});
      tbl.push_back('{0, 1, 4'b0000, 4'b0000, 0, 2'd0, 4'b0000, 1});
      tbl.push_back('{0, 1, 4'b0000, 4'b0000, 0, 2'd0, 4'b0000, 1});
      tbl.push_back('{0, 1, 4'b0000, 4'b0000, 0, 2'd0, 4'b0001, 1});
      tbl.push_back('{0, 1, 4'b0000, 4'b0000, 0, 2'd0, 4'b0000, 0});
      // all four requesting after reset: full rotation, done trails by 3
      tbl.push_back('{1, 1, 4'b1111, 4'b0000, 0, 2'd0, 4'b0000, 0});
      tbl.push_back('{0, 1, 4'b1111, 4'b0001, 1, 2'd0, 4'b0000, 1});
      tbl.push_back('{0, 1, 4'b1111, 4'b0010, 1, 2'd1, 4'b0000, 1});
      tbl.push_back('{0, 1, 4'b1111, 4'b0100, 1, 2'd2, 4'b0000, 1});
      tbl.push_back('{0, 1, 4'b1111, 4'b1000, 1, 2'd3, 4'b0001, 1});
      tbl.push_back('{0, 1, 4'b1111, 4'b0001, 1, 2'd0, 4'b0010, 1});
      tbl.push_back('{0, 1, 4'b0000, 4'b0000, 0, 2'd0, 4'b0100, 1});
      tbl.push_back('{0, 1, 4'b0000, 4'b0000, 0, 2'd0, 4'b1000, 1});
      tbl.push_back('{0, 1, 4'b0000, 4'b0000, 0, 2'd0, 4'b0001, 1});
      tbl.push_back('{0, 1, 4'b0000, 4'b0000, 0, 2'd0, 4'b0000, 0});
      // lone requester held: grant every other cycle
      tbl.push_back('{0, 1, 4'b0100, 4'b0100, 1, 2'd2, 4'b0000, 1});
      tbl.push_back('{0, 1, 4'b0100, 4'b0000, 0, 2'd2, 4'b0000, 1});
      tbl.push_back('{0, 1, 4'b0100, 4'b0100, 1, 2'd2, 4'b0000, 1});
      tbl.push_back('{0, 1, 4'b0100, 4'b0000, 0, 2'd2, 4'b0100, 1});
      tbl.push_back('{0, 1, 4'b0100, 4'b0100, 1, 2'd2, 4'b0000, 1});
      tbl.push_back('{0, 1, 4'b0000, 4'b0000, 0, 2'd2, 4'b0100, 1});
      tbl.push_back('{0, 1, 4'b0000, 4'b0000, 0, 2'd2, 4'b0000, 1});
      tbl.push_back('{0, 1, 4'b0000, 4'b0000, 0, 2'd2, 4'b0100, 1});
      tbl.push_back('{0, 1, 4'b0000, 4'b0000, 0, 2'd2, 4'b0000, 0});
      // en gating from pointer 0, then en dropped with results in flight
      tbl.push_back('{1, 0, 4'b1010, 4'b0000, 0, 2'd0, 4'b0000, 0});
      tbl.push_back('{0, 0, 4'b1010, 4'b0000, 0, 2'd0, 4'b0000, 0});
      tbl.push_back('{0, 0, 4'b1010, 4'b0000, 0, 2'd0, 4'b0000, 0});
      tbl.push_back('{0, 1, 4'b1010, 4'b0010, 1, 2'd1, 4'b0000, 1});
      tbl.push_back('{0, 1, 4'b1010, 4'b1000, 1, 2'd3, 4'b0000, 1});
      tbl.push_back('{0, 0, 4'b0000, 4'b0000, 0, 2'd3, 4'b0000, 1});
      tbl.push_back('{0, 0, 4'b0000, 4'b0000, 0, 2'd3, 4'b0010, 1});
      tbl.push_back('{0, 0, 4'b0000, 4'b0000, 0, 2'd3, 4'b1000, 1});
      tbl.push_back('{0, 0, 4'b0000, 4'b0000, 0, 2'd3, 4'b0000, 0});

      rst     = 1'b1;
      bus.en  = 1'b0;
      bus.req = 4'b0000;
`ifdef PIPE_ARB_LOCK_EN
      bus.lock = 4'b0000;
`endif
      step();
      step();
      chk_all("reset", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);

      foreach (tbl[i]) begin
         rst     = tbl[i].rst;
         bus.en  = tbl[i].en;
         bus.req = tbl[i].req;
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].grant, tbl[i].iv, tbl[i].sel,
                 tbl[i].done, tbl[i].busy);
      end

      // reset one cycle after a grant: the in-flight tag must vanish
      rst = 1'b0; bus.en = 1'b1; bus.req = 4'b0001;
      step();
      chk("midrst.grant", 8'(bus.grant), 8'h01);
      bus.en = 1'b0; bus.req = 4'b0000;
      step();
      chk("midrst.busy_inflight", 8'(bus.busy), 8'h1);
      rst = 1'b1;
      step();
      chk_all("midrst.rst", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         chk($sformatf("midrst.done%0d", c), 8'(bus.done), 8'h00);
         chk($sformatf("midrst.busy%0d", c), 8'(bus.busy), 8'h0);
      end
      bus.en = 1'b1; bus.req = 4'b0011;
      step();
      chk("midrst.ptr0_grant", 8'(bus.grant), 8'h01);
      chk("midrst.ptr0_sel",   8'(bus.sel),   8'h00);
      bus.req = 4'b0000;
      step();

`ifdef PIPE_ARB_LOCK_EN
      begin
         logic [3:0] exp_g [6];
         exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0010;
         exp_g[3] = 4'b0010; exp_g[4] = 4'b0010; exp_g[5] = 4'b0100;
         rst = 1'b1;
         step();
         rst = 1'b0; bus.en = 1'b1; bus.req = 4'b1111; bus.lock = 4'b0010;
         for (int c = 0; c < 6; c++) begin
            if (c == 5) bus.lock = 4'b0000;
            step();
            chk($sformatf("lock.grant%0d", c), 8'(bus.grant), 8'(exp_g[c]));
         end
         bus.req = 4'b0000;
         step();
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
